// File: rtl/layer_mem_sequencer.sv
// layer_mem_sequencer
// Walks one fully-connected layer over the activation RAM and the weight ROM.
// Both memories have a one-cycle synchronous read.
// The block issues read addresses and registers the element tags so that they
// line up with the memory read data. The MAC applies backpressure through
// mac_ready_i.
// Optional output writeback: define LAYER_SEQ_WB_EN to register accumulator
// results into an output RAM write port and add the WB_WAIT state.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start_i
// S_RUN     | issuing addresses, presenting elements to the MAC
// S_DRAIN   | final address issued, waiting for the final element to be taken
// S_WB_WAIT | (writeback build) waiting for OUT_SIZE result writes
// S_DONE    | one-cycle completion pulse, then back to idle
module layer_mem_sequencer #(
   parameter  int IN_SIZE  = 784,
   parameter  int OUT_SIZE = 10,
   parameter  int ACC_W    = 16,
   localparam int AW       = $clog2(IN_SIZE),
   localparam int WW       = $clog2(IN_SIZE * OUT_SIZE),
   localparam int NW       = $clog2(OUT_SIZE)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [AW-1:0]    in_addr_o,
   output logic [WW-1:0]    w_addr_o,
   output logic             rd_valid_o,
   output logic             rd_first_o,
   output logic             rd_last_o,
   output logic [NW-1:0]    rd_neuron_o,
   input  logic             mac_ready_i,
   input  logic             acc_valid_i,
   input  logic [ACC_W-1:0] acc_data_i,
   output logic             out_wen_o,
   output logic [NW-1:0]    out_addr_o,
   output logic [ACC_W-1:0] out_data_o
);

   localparam logic [AW-1:0] IN_LAST  = AW'(IN_SIZE - 1);
   localparam logic [NW-1:0] OUT_LAST = NW'(OUT_SIZE - 1);

`ifdef LAYER_SEQ_WB_EN
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WB_WAIT, S_DONE} state_t;
   localparam int CW = $clog2(OUT_SIZE + 1);
   logic [CW-1:0]    wb_cnt_q;
   logic             out_wen_q;
   logic [NW-1:0]    out_addr_q;
   logic [ACC_W-1:0] out_data_q;
   logic             wb_accept;
`else
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
`endif

   state_t        state_q;
   logic          busy_q, done_q;
   logic [AW-1:0] i_q, i_d;
   logic [NW-1:0] n_q, n_d;
   logic [WW-1:0] w_q, w_d;
   logic          rd_valid_q, rd_first_q, rd_last_q;
   logic [NW-1:0] rd_neuron_q;
   logic          advance, final_addr;

   // Next address values; w_addr is a running counter so no multiplier is needed.
   always_comb begin
      i_d        = i_q + AW'(1);
      n_d        = n_q;
      w_d        = w_q + WW'(1);
      if (i_q == IN_LAST) begin
         i_d = '0;
         n_d = n_q + NW'(1);
      end
      advance    = !rd_valid_q || mac_ready_i;
      final_addr = (i_q == IN_LAST) && (n_q == OUT_LAST);
   end

`ifdef LAYER_SEQ_WB_EN
   // A result is taken only while the layer is active and writes remain.
   assign wb_accept = acc_valid_i && (wb_cnt_q < CW'(OUT_SIZE)) &&
                      (state_q == S_RUN || state_q == S_DRAIN || state_q == S_WB_WAIT);
`endif

   // Layer FSM, address issue, tag pipeline and optional writeback.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         i_q         <= '0;
         n_q         <= '0;
         w_q         <= '0;
         rd_valid_q  <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_neuron_q <= '0;
`ifdef LAYER_SEQ_WB_EN
         wb_cnt_q    <= '0;
         out_wen_q   <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef LAYER_SEQ_WB_EN
         out_wen_q <= 1'b0;
         if (wb_accept) begin
            out_wen_q  <= 1'b1;
            out_addr_q <= wb_cnt_q[NW-1:0];
            out_data_q <= acc_data_i;
            wb_cnt_q   <= wb_cnt_q + CW'(1);
         end
`endif
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  i_q     <= '0;
                  n_q     <= '0;
                  w_q     <= '0;
`ifdef LAYER_SEQ_WB_EN
                  wb_cnt_q <= '0;
`endif
               end
            end
            S_RUN: begin
               // Tags describe the address held this cycle, which the memory
               // is reading at this edge.
               if (advance) begin
                  rd_valid_q  <= 1'b1;
                  rd_first_q  <= (i_q == '0);
                  rd_last_q   <= (i_q == IN_LAST);
                  rd_neuron_q <= n_q;
                  if (final_addr) begin
                     state_q <= S_DRAIN;
                  end else begin
                     i_q <= i_d;
                     n_q <= n_d;
                     w_q <= w_d;
                  end
               end
            end
            S_DRAIN: begin
               if (rd_valid_q && mac_ready_i) begin
                  rd_valid_q  <= 1'b0;
                  rd_first_q  <= 1'b0;
                  rd_last_q   <= 1'b0;
                  rd_neuron_q <= '0;
                  if (rd_last_q && rd_neuron_q == OUT_LAST) begin
`ifdef LAYER_SEQ_WB_EN
                     state_q <= S_WB_WAIT;
`else
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end
               end
            end
`ifdef LAYER_SEQ_WB_EN
            S_WB_WAIT: begin
               if (wb_cnt_q == CW'(OUT_SIZE)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
`endif
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign in_addr_o   = i_q;
   assign w_addr_o    = w_q;
   assign rd_valid_o  = rd_valid_q;
   assign rd_first_o  = rd_first_q;
   assign rd_last_o   = rd_last_q;
   assign rd_neuron_o = rd_neuron_q;

`ifdef LAYER_SEQ_WB_EN
   assign out_wen_o  = out_wen_q;
   assign out_addr_o = out_addr_q;
   assign out_data_o = out_data_q;
`else
   logic unused_acc;
   assign unused_acc = ^{acc_valid_i, acc_data_i};
   assign out_wen_o  = 1'b0;
   assign out_addr_o = '0;
   assign out_data_o = '0;
`endif

endmodule
